// File: rtl/pipe_ctrl_v2_if.sv
// Handshake bundle between the pipeline controller and its requesters (ex, clint, jtag)
// and its consumers (pc_reg, if_id, id_ex, branch predictor).
interface pipe_ctrl_v2_if #(
  parameter int ADDR_W   = 32,
  parameter int NUM_HOLD = 4
);
  logic [ADDR_W-1:0]     inst_addr_i;
  logic                  branch_valid_i;
  logic                  bp_taken_i;
  logic                  jump_flag_i;
  logic [ADDR_W-1:0]     jump_addr_i;
  logic [NUM_HOLD-1:0]   hold_req_i;
  logic [2*NUM_HOLD-1:0] hold_lvl_i;
  logic                  halt_req_i;

  logic                  jump_flag_o;
  logic [ADDR_W-1:0]     jump_addr_o;
  logic [2:0]            hold_flag_o;
  logic                  halted_o;
  logic                  bp_upd_valid_o;
  logic                  bp_upd_taken_o;
  logic [ADDR_W-1:0]     bp_upd_addr_o;

  modport master (
    output inst_addr_i, branch_valid_i, bp_taken_i, jump_flag_i, jump_addr_i,
           hold_req_i, hold_lvl_i, halt_req_i,
    input  jump_flag_o, jump_addr_o, hold_flag_o, halted_o,
           bp_upd_valid_o, bp_upd_taken_o, bp_upd_addr_o
  );

  modport slave (
    input  inst_addr_i, branch_valid_i, bp_taken_i, jump_flag_i, jump_addr_i,
           hold_req_i, hold_lvl_i, halt_req_i,
    output jump_flag_o, jump_addr_o, hold_flag_o, halted_o,
           bp_upd_valid_o, bp_upd_taken_o, bp_upd_addr_o
  );
endinterface

// File: rtl/pipe_ctrl_v2.sv
// Pipeline control: branch redirect, hold merge, flush stretch, debug-halt drain FSM.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_v2 #(
  parameter int ADDR_W       = 32,
  parameter int NUM_HOLD     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_v2_if.slave    bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_br_o,
  output logic [CNT_W-1:0] perf_mis_o,
  output logic [CNT_W-1:0] perf_flush_o
`endif
);

  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  if (FLUSH_CYCLES < 1 || DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl_v2: FLUSH_CYCLES, DRAIN_CYCLES and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t              state_p1, state_nxt;
  logic [FL_W-1:0]     flush_cnt_p1;
  logic [DR_W-1:0]     drain_cnt_p1, drain_nxt;
  logic                halted_p1;
  logic                upd_vld_p1, upd_taken_p1;
  logic [ADDR_W-1:0]   upd_addr_p1;

  logic                mispredict_p0, redirect_p0, flush_act_p0;
  logic [ADDR_W-1:0]   target_p0;
  logic [2:0]          req_lvl_p0, fsm_lvl_p0, flush_lvl_p0;

  function automatic logic [2:0] hold_max(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---- stage p0: combinational resolve, redirect and hold merge ----
  assign mispredict_p0 = bus.branch_valid_i & (bus.jump_flag_i ^ bus.bp_taken_i);
  assign redirect_p0   = mispredict_p0 | (~bus.branch_valid_i & bus.jump_flag_i);
  // A taken prediction that turned out wrong falls back to the sequential PC.
  assign target_p0     = (bus.branch_valid_i & bus.bp_taken_i) ?
                         (bus.inst_addr_i + ADDR_W'(4)) : bus.jump_addr_i;
  assign flush_act_p0  = redirect_p0 | (flush_cnt_p1 != '0);
  assign flush_lvl_p0  = flush_act_p0 ? HOLD_ID : HOLD_NONE;

  assign bus.jump_flag_o = redirect_p0;
  assign bus.jump_addr_o = redirect_p0 ? target_p0 : '0;

  always_comb begin
    req_lvl_p0 = HOLD_NONE;
    for (int i = 0; i < NUM_HOLD; i++) begin
      if (bus.hold_req_i[i])
        req_lvl_p0 = hold_max(req_lvl_p0, {1'b0, bus.hold_lvl_i[2*i +: 2]});
    end
  end

  always_comb begin
    state_nxt  = state_p1;
    drain_nxt  = drain_cnt_p1;
    fsm_lvl_p0 = HOLD_NONE;
    case (state_p1)
      ST_RUN: begin
        if (bus.halt_req_i) begin
          state_nxt = ST_DRAIN;
          drain_nxt = DR_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (!bus.halt_req_i) begin
          state_nxt = ST_RUN;
          drain_nxt = '0;
        end else begin
          fsm_lvl_p0 = HOLD_PC;
          // Drain only counts down while no flush is in flight.
          if (!flush_act_p0) begin
            if (drain_cnt_p1 == '0) state_nxt = ST_HALTED;
            else                    drain_nxt = drain_cnt_p1 - DR_W'(1);
          end
        end
      end
      ST_HALTED: begin
        fsm_lvl_p0 = HOLD_ID;
        if (!bus.halt_req_i) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign bus.hold_flag_o = hold_max(hold_max(flush_lvl_p0, req_lvl_p0), fsm_lvl_p0);

  // ---- stage p1: registered control state and predictor update ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1     <= ST_RUN;
      drain_cnt_p1 <= '0;
      flush_cnt_p1 <= '0;
      halted_p1    <= 1'b0;
      upd_vld_p1   <= 1'b0;
      upd_taken_p1 <= 1'b0;
      upd_addr_p1  <= '0;
    end else begin
      state_p1     <= state_nxt;
      drain_cnt_p1 <= drain_nxt;
      halted_p1    <= (state_nxt == ST_HALTED);
      if (redirect_p0)
        flush_cnt_p1 <= FL_W'(FLUSH_CYCLES - 1);
      else if (flush_cnt_p1 != '0)
        flush_cnt_p1 <= flush_cnt_p1 - FL_W'(1);
      upd_vld_p1   <= bus.branch_valid_i;
      upd_taken_p1 <= bus.branch_valid_i & bus.jump_flag_i;
      upd_addr_p1  <= bus.branch_valid_i ? bus.inst_addr_i : '0;
    end
  end

  assign bus.halted_o       = halted_p1;
  assign bus.bp_upd_valid_o = upd_vld_p1;
  assign bus.bp_upd_taken_o = upd_taken_p1;
  assign bus.bp_upd_addr_o  = upd_addr_p1;

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  // ---- stage p1: saturating performance counters ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_o    <= '0;
      perf_mis_o   <= '0;
      perf_flush_o <= '0;
    end else begin
      if (bus.branch_valid_i) perf_br_o    <= sat_inc(perf_br_o);
      if (mispredict_p0)      perf_mis_o   <= sat_inc(perf_mis_o);
      if (flush_act_p0)       perf_flush_o <= sat_inc(perf_flush_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2: redirect, hold merge, halt drain, freeze, async reset.
module tb_pipe_ctrl_v2;
  localparam int ADDR_W = 32;
  localparam int NUM_HOLD = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_v2_if #(.ADDR_W(ADDR_W), .NUM_HOLD(NUM_HOLD)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_br, perf_mis, perf_flush;
`endif

  pipe_ctrl_v2 #(
    .ADDR_W(ADDR_W), .NUM_HOLD(NUM_HOLD), .FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_br_o(perf_br), .perf_mis_o(perf_mis), .perf_flush_o(perf_flush)
`endif
  );

  task automatic set_idle();
    bus.inst_addr_i = '0; bus.branch_valid_i = 1'b0; bus.bp_taken_i = 1'b0;
    bus.jump_flag_i = 1'b0; bus.jump_addr_i = '0; bus.hold_req_i = '0;
    bus.hold_lvl_i = '0;
  endtask

  task automatic set_branch(input logic bv, input logic bt, input logic jf,
                            input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] ja);
    bus.branch_valid_i = bv; bus.bp_taken_i = bt; bus.jump_flag_i = jf;
    bus.inst_addr_i = ia; bus.jump_addr_i = ja;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle(); bus.halt_req_i = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL rst_hold got=%0d exp=0", bus.hold_flag_o); end
    n_cmp++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL rst_halted got=%0b exp=0", bus.halted_o); end
    n_cmp++; if (bus.bp_upd_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_upd_valid got=%0b exp=0", bus.bp_upd_valid_o); end
    n_cmp++; if (bus.jump_flag_o !== 1'b0 || bus.jump_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_jump got=%0b/%h exp=0/0", bus.jump_flag_o, bus.jump_addr_o); end
    bus.hold_req_i = 4'b0010; bus.hold_lvl_i = 8'b0000_1000;
    #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd2) begin n_err++; $display("FAIL rst_hold_req got=%0d exp=2", bus.hold_flag_o); end
    set_idle();
    step(); rst = 1'b0; #1;
  endtask

  task automatic test_mispredict();
    set_branch(1'b1, 1'b1, 1'b0, 32'h100, 32'h5555); #1;
    n_cmp++; if (bus.jump_flag_o !== 1'b1) begin n_err++; $display("FAIL mt_flag got=%0b exp=1", bus.jump_flag_o); end
    n_cmp++; if (bus.jump_addr_o !== 32'h104) begin n_err++; $display("FAIL mt_addr got=%h exp=104", bus.jump_addr_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL mt_hold0 got=%0d exp=3", bus.hold_flag_o); end
    step(); set_idle(); #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL mt_hold1 got=%0d exp=3", bus.hold_flag_o); end
    n_cmp++; if ({bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 2'b10 || bus.bp_upd_addr_o !== 32'h100) begin n_err++; $display("FAIL mt_upd got=%b/%h exp=10/100", {bus.bp_upd_valid_o, bus.bp_upd_taken_o}, bus.bp_upd_addr_o); end
    step();
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL mt_hold2 got=%0d exp=0", bus.hold_flag_o); end
    n_cmp++; if (bus.bp_upd_valid_o !== 1'b0) begin n_err++; $display("FAIL mt_upd_clear got=%0b exp=0", bus.bp_upd_valid_o); end
    set_branch(1'b1, 1'b0, 1'b1, 32'h200, 32'h2000); #1;
    n_cmp++; if (bus.jump_flag_o !== 1'b1 || bus.jump_addr_o !== 32'h2000) begin n_err++; $display("FAIL mn_redirect got=%0b/%h exp=1/2000", bus.jump_flag_o, bus.jump_addr_o); end
    step(); set_idle(); #1;
    n_cmp++; if ({bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 2'b11 || bus.bp_upd_addr_o !== 32'h200) begin n_err++; $display("FAIL mn_upd got=%b/%h exp=11/200", {bus.bp_upd_valid_o, bus.bp_upd_taken_o}, bus.bp_upd_addr_o); end
    step();
  endtask

  task automatic test_correct_and_jump();
    set_branch(1'b1, 1'b1, 1'b1, 32'h300, 32'h3300); #1;
    n_cmp++; if (bus.jump_flag_o !== 1'b0 || bus.jump_addr_o !== 32'h0) begin n_err++; $display("FAIL ok_noredir got=%0b/%h exp=0/0", bus.jump_flag_o, bus.jump_addr_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL ok_hold got=%0d exp=0", bus.hold_flag_o); end
    step(); set_branch(1'b0, 1'b1, 1'b1, 32'h0, 32'h40); #1;
    n_cmp++; if ({bus.bp_upd_valid_o, bus.bp_upd_taken_o} !== 2'b11 || bus.bp_upd_addr_o !== 32'h300) begin n_err++; $display("FAIL ok_upd got=%b/%h exp=11/300", {bus.bp_upd_valid_o, bus.bp_upd_taken_o}, bus.bp_upd_addr_o); end
    n_cmp++; if (bus.jump_flag_o !== 1'b1 || bus.jump_addr_o !== 32'h40) begin n_err++; $display("FAIL jmp_redirect got=%0b/%h exp=1/40", bus.jump_flag_o, bus.jump_addr_o); end
    step(); set_branch(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234); #1;
    n_cmp++; if (bus.bp_upd_valid_o !== 1'b0) begin n_err++; $display("FAIL jmp_no_upd got=%0b exp=0", bus.bp_upd_valid_o); end
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL reload_hold got=%0d exp=3", bus.hold_flag_o); end
    n_cmp++; if (bus.jump_addr_o !== 32'h0 || bus.jump_flag_o !== 1'b1) begin n_err++; $display("FAIL wrap_addr got=%0b/%h exp=1/0", bus.jump_flag_o, bus.jump_addr_o); end
    step(); set_idle(); step(); #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL flush_done got=%0d exp=0", bus.hold_flag_o); end
  endtask

  task automatic test_hold_merge();
    bus.hold_req_i = 4'b0101; bus.hold_lvl_i = 8'b11_10_11_01; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd2) begin n_err++; $display("FAIL merge_a got=%0d exp=2", bus.hold_flag_o); end
    bus.hold_lvl_i = 8'b11_10_11_11; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL merge_b got=%0d exp=3", bus.hold_flag_o); end
    bus.hold_req_i = 4'b1000; bus.hold_lvl_i = 8'b01_11_11_11; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd1) begin n_err++; $display("FAIL merge_ignore got=%0d exp=1", bus.hold_flag_o); end
    set_idle(); #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL merge_none got=%0d exp=0", bus.hold_flag_o); end
  endtask

  task automatic test_halt();
    bus.halt_req_i = 1'b1; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL halt_c0 got=%0d exp=0", bus.hold_flag_o); end
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++; if (bus.hold_flag_o !== 3'd1 || bus.halted_o !== 1'b0) begin n_err++; $display("FAIL halt_drain c%0d got=%0d/%0b exp=1/0", c, bus.hold_flag_o, bus.halted_o); end
    end
    step();
    n_cmp++; if (bus.hold_flag_o !== 3'd3 || bus.halted_o !== 1'b1) begin n_err++; $display("FAIL halt_enter got=%0d/%0b exp=3/1", bus.hold_flag_o, bus.halted_o); end
    bus.halt_req_i = 1'b0; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd3) begin n_err++; $display("FAIL halt_release_same got=%0d exp=3", bus.hold_flag_o); end
    step();
    n_cmp++; if (bus.hold_flag_o !== 3'd0 || bus.halted_o !== 1'b0) begin n_err++; $display("FAIL halt_resume got=%0d/%0b exp=0/0", bus.hold_flag_o, bus.halted_o); end
  endtask

  task automatic test_drain_freeze();
    logic [2:0] exp_hold [1:6] = '{3'd1, 3'd3, 3'd3, 3'd1, 3'd1, 3'd3};
    bus.halt_req_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) set_branch(1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
      if (c == 3) set_idle();
      #1;
      n_cmp++; if (bus.hold_flag_o !== exp_hold[c] || bus.halted_o !== (c == 6)) begin n_err++; $display("FAIL freeze c%0d got=%0d/%0b exp=%0d/%0b", c, bus.hold_flag_o, bus.halted_o, exp_hold[c], c == 6); end
    end
    bus.halt_req_i = 1'b0; step();
    n_cmp++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL freeze_exit got=%0b exp=0", bus.halted_o); end
    bus.halt_req_i = 1'b1; step();
    n_cmp++; if (bus.hold_flag_o !== 3'd1) begin n_err++; $display("FAIL abort_drain got=%0d exp=1", bus.hold_flag_o); end
    bus.halt_req_i = 1'b0; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0) begin n_err++; $display("FAIL abort_immediate got=%0d exp=0", bus.hold_flag_o); end
    step(); step();
    n_cmp++; if (bus.hold_flag_o !== 3'd0 || bus.halted_o !== 1'b0) begin n_err++; $display("FAIL abort_run got=%0d/%0b exp=0/0", bus.hold_flag_o, bus.halted_o); end
  endtask

  task automatic test_reset_mid();
    bus.halt_req_i = 1'b1; step(); step();
    set_branch(1'b1, 1'b1, 1'b0, 32'h500, 32'h0); step();
    set_idle(); rst = 1'b1; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0 || bus.halted_o !== 1'b0) begin n_err++; $display("FAIL rstmid_drain got=%0d/%0b exp=0/0", bus.hold_flag_o, bus.halted_o); end
    n_cmp++; if (bus.bp_upd_valid_o !== 1'b0 || bus.bp_upd_addr_o !== 32'h0) begin n_err++; $display("FAIL rstmid_upd got=%0b/%h exp=0/0", bus.bp_upd_valid_o, bus.bp_upd_addr_o); end
    step(); rst = 1'b0;
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if (bus.halted_o !== 1'b1) begin n_err++; $display("FAIL rstmid_rehalt got=%0b exp=1", bus.halted_o); end
    rst = 1'b1; #1;
    n_cmp++; if (bus.hold_flag_o !== 3'd0 || bus.halted_o !== 1'b0) begin n_err++; $display("FAIL rstmid_halted got=%0d/%0b exp=0/0", bus.hold_flag_o, bus.halted_o); end
    bus.halt_req_i = 1'b0; step(); rst = 1'b0; #1;
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    rst = 1'b1; step(); rst = 1'b0; #1;
    n_cmp++; if (perf_br !== 4'd0 || perf_mis !== 4'd0 || perf_flush !== 4'd0) begin n_err++; $display("FAIL perf_rst got=%0d/%0d/%0d exp=0/0/0", perf_br, perf_mis, perf_flush); end
    set_branch(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 16; i++) step();
    set_idle(); step();
    n_cmp++; if (perf_mis !== 4'd15 || perf_br !== 4'd15 || perf_flush !== 4'd15) begin n_err++; $display("FAIL perf_sat got=%0d/%0d/%0d exp=15/15/15", perf_br, perf_mis, perf_flush); end
  endtask
`endif

  initial begin
    bus.halt_req_i = 1'b0;
    test_reset();
    test_mispredict();
    test_correct_and_jump();
    test_hold_merge();
    test_halt();
    test_drain_freeze();
    test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
